// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between instruction fetch (I)
// and the load/store port (D); D has priority, I is forced after a D streak.
module mem_port_arbiter #(
   parameter int MEM_LATENCY  = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req_valid_i,
   output logic        i_req_ready_o,
   input  logic [31:0] i_addr_i,
   output logic        i_rsp_valid_o,
   output logic [31:0] i_rsp_data_o,
   input  logic        d_req_valid_i,
   output logic        d_req_ready_o,
   input  logic [31:0] d_addr_i,
   input  logic [31:0] d_wdata_i,
   input  logic        d_write_i,
   input  logic [1:0]  d_width_i,
   output logic        d_rsp_valid_o,
   output logic [31:0] d_rsp_data_o,
   output logic        d_rsp_err_o,
   output logic        mem_en_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_be_o,
   input  logic [31:0] mem_rdata_i
);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

   localparam logic [3:0] LAT_LAST   = 4'(MEM_LATENCY - 1);
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   function automatic logic [3:0] calc_be(input logic [1:0] a, input logic [1:0] w);
      case (w)
         2'd0:    calc_be = 4'b0001 << a;
         2'd1:    calc_be = 4'b0011 << {a[1], 1'b0};
         default: calc_be = 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] lane_rep(input logic [31:0] wd, input logic [1:0] w);
      case (w)
         2'd0:    lane_rep = {4{wd[7:0]}};
         2'd1:    lane_rep = {2{wd[15:0]}};
         default: lane_rep = wd;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [1:0] a, input logic [1:0] w);
      case (w)
         2'd0:    is_misaligned = 1'b0;
         2'd1:    is_misaligned = a[0];
         default: is_misaligned = (a != 2'b00);
      endcase
   endfunction

   state_t      state_r;
   logic [3:0]  streak_r;
   logic [3:0]  cnt_r;
   logic        owner_d_r;
   logic        write_r;
   logic        err_r;
   logic        mem_en_r;
   logic        mem_we_r;
   logic [31:0] mem_addr_r;
   logic [31:0] mem_wdata_r;
   logic [3:0]  mem_be_r;
   logic        i_rsp_valid_r;
   logic [31:0] i_rsp_data_r;
   logic        d_rsp_valid_r;
   logic [31:0] d_rsp_data_r;
   logic        d_rsp_err_r;

   logic grant_i_s;
   logic grant_d_s;
   logic d_mis_s;

   assign grant_i_s = (state_r == ST_IDLE) && i_req_valid_i &&
                      (!d_req_valid_i || (streak_r == STARVE_MAX));
   assign grant_d_s = (state_r == ST_IDLE) && d_req_valid_i && !grant_i_s;
   assign d_mis_s   = is_misaligned(d_addr_i[1:0], d_width_i);

   assign i_req_ready_o = grant_i_s;
   assign d_req_ready_o = grant_d_s;
   assign mem_en_o      = mem_en_r;
   assign mem_we_o      = mem_we_r;
   assign mem_addr_o    = mem_addr_r;
   assign mem_wdata_o   = mem_wdata_r;
   assign mem_be_o      = mem_be_r;
   assign i_rsp_valid_o = i_rsp_valid_r;
   assign i_rsp_data_o  = i_rsp_data_r;
   assign d_rsp_valid_o = d_rsp_valid_r;
   assign d_rsp_data_o  = d_rsp_data_r;
   assign d_rsp_err_o   = d_rsp_err_r;

   // Access sequencer; mem_* and rsp_* default to 0 so they only pulse in ISSUE/RESP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         streak_r      <= 4'd0;
         cnt_r         <= 4'd0;
         owner_d_r     <= 1'b0;
         write_r       <= 1'b0;
         err_r         <= 1'b0;
         mem_en_r      <= 1'b0;
         mem_we_r      <= 1'b0;
         mem_addr_r    <= 32'h0;
         mem_wdata_r   <= 32'h0;
         mem_be_r      <= 4'h0;
         i_rsp_valid_r <= 1'b0;
         i_rsp_data_r  <= 32'h0;
         d_rsp_valid_r <= 1'b0;
         d_rsp_data_r  <= 32'h0;
         d_rsp_err_r   <= 1'b0;
      end else begin
         mem_en_r      <= 1'b0;
         mem_we_r      <= 1'b0;
         mem_addr_r    <= 32'h0;
         mem_wdata_r   <= 32'h0;
         mem_be_r      <= 4'h0;
         i_rsp_valid_r <= 1'b0;
         i_rsp_data_r  <= 32'h0;
         d_rsp_valid_r <= 1'b0;
         d_rsp_data_r  <= 32'h0;
         d_rsp_err_r   <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (grant_i_s) begin
                  state_r    <= ST_ISSUE;
                  owner_d_r  <= 1'b0;
                  write_r    <= 1'b0;
                  err_r      <= 1'b0;
                  streak_r   <= 4'd0;
                  mem_en_r   <= 1'b1;
                  mem_addr_r <= i_addr_i & 32'hFFFF_FFFC;
                  mem_be_r   <= 4'hF;
               end else if (grant_d_s) begin
                  state_r     <= ST_ISSUE;
                  owner_d_r   <= 1'b1;
                  write_r     <= d_write_i;
                  err_r       <= d_mis_s;
                  mem_en_r    <= !d_mis_s;
                  mem_we_r    <= d_write_i && !d_mis_s;
                  mem_addr_r  <= d_mis_s ? 32'h0 : (d_addr_i & 32'hFFFF_FFFC);
                  mem_be_r    <= d_mis_s ? 4'h0 : calc_be(d_addr_i[1:0], d_width_i);
                  // Loads drive no write data onto the bus
                  mem_wdata_r <= (d_write_i && !d_mis_s) ? lane_rep(d_wdata_i, d_width_i) : 32'h0;
                  if (i_req_valid_i && (streak_r != STARVE_MAX)) begin
                     streak_r <= streak_r + 4'd1;
                  end else begin
                     streak_r <= streak_r;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               if (write_r || err_r) begin
                  state_r       <= ST_RESP;
                  d_rsp_valid_r <= 1'b1;
                  d_rsp_err_r   <= err_r;
               end else begin
                  state_r <= ST_WAIT;
                  cnt_r   <= 4'd0;
               end
            end
            ST_WAIT: begin
               if (cnt_r == LAT_LAST) begin
                  state_r <= ST_RESP;
                  if (owner_d_r) begin
                     d_rsp_valid_r <= 1'b1;
                     d_rsp_data_r  <= mem_rdata_i;
                  end else begin
                     i_rsp_valid_r <= 1'b1;
                     i_rsp_data_r  <= mem_rdata_i;
                  end
               end else begin
                  cnt_r <= cnt_r + 4'd1;
               end
            end
            ST_RESP: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-timeline model:
// each accepted request predicts its memory strobe and response cycle.
module tb_mem_port_arbiter;

   localparam int L = 3;
   localparam int S = 4;

   logic        clk;
   logic        rst_n;
   logic        i_req_valid_i;
   logic        i_req_ready_o;
   logic [31:0] i_addr_i;
   logic        i_rsp_valid_o;
   logic [31:0] i_rsp_data_o;
   logic        d_req_valid_i;
   logic        d_req_ready_o;
   logic [31:0] d_addr_i;
   logic [31:0] d_wdata_i;
   logic        d_write_i;
   logic [1:0]  d_width_i;
   logic        d_rsp_valid_o;
   logic [31:0] d_rsp_data_o;
   logic        d_rsp_err_o;
   logic        mem_en_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_rdata_i;

   mem_port_arbiter #(.MEM_LATENCY(L), .STARVE_LIMIT(S)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid_i(i_req_valid_i), .i_req_ready_o(i_req_ready_o), .i_addr_i(i_addr_i),
      .i_rsp_valid_o(i_rsp_valid_o), .i_rsp_data_o(i_rsp_data_o),
      .d_req_valid_i(d_req_valid_i), .d_req_ready_o(d_req_ready_o), .d_addr_i(d_addr_i),
      .d_wdata_i(d_wdata_i), .d_write_i(d_write_i), .d_width_i(d_width_i),
      .d_rsp_valid_o(d_rsp_valid_o), .d_rsp_data_o(d_rsp_data_o), .d_rsp_err_o(d_rsp_err_o),
      .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;

   // requester state
   bit          i_pend, d_pend;
   logic [31:0] i_a, d_a, d_wd;
   bit          d_we;
   logic [1:0]  d_w;
   int          gen_pct;

   // reference model state
   int          cyc;
   bit          busy;
   int          t_hand;
   int          streak;
   bit          m_own_d, m_we, m_err;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_be;
   int          m_rsp_at;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, obs, exp);
      end
   endtask

   task automatic drive_inputs();
      if (!i_pend && $urandom_range(99) < gen_pct) begin
         i_pend = 1'b1;
         i_a    = $urandom;
      end
      if (!d_pend && $urandom_range(99) < gen_pct) begin
         d_pend = 1'b1;
         d_a    = $urandom;
         d_wd   = $urandom;
         d_we   = $urandom_range(1);
         d_w    = 2'($urandom_range(3));
      end
      i_req_valid_i = i_pend;
      i_addr_i      = i_a;
      d_req_valid_i = d_pend;
      d_addr_i      = d_a;
      d_wdata_i     = d_wd;
      d_write_i     = d_we;
      d_width_i     = d_w;
      mem_rdata_i   = $urandom;
   endtask

   task automatic check_and_advance();
      bit          gi, gd;
      bit          e_ir, e_dr, e_en, e_we, e_iv, e_dv, e_de;
      logic [31:0] e_addr, e_wdata, e_id, e_dd;
      logic [3:0]  e_be;
      int          k, w, lo;
      gi = 0; gd = 0; e_ir = 0; e_dr = 0; e_en = 0; e_we = 0;
      e_iv = 0; e_dv = 0; e_de = 0;
      e_addr = 32'h0; e_wdata = 32'h0; e_id = 32'h0; e_dd = 32'h0; e_be = 4'h0;
      k = cyc - t_hand;
      if (!busy) begin
         gi   = i_pend && (!d_pend || streak == S);
         gd   = d_pend && !gi;
         e_ir = gi;
         e_dr = gd;
      end else begin
         if (k == 1) begin
            e_en = !m_err; e_we = m_we; e_addr = m_addr; e_wdata = m_wdata; e_be = m_be;
         end
         if (k == 1 + L && !m_we && !m_err) m_rdata = mem_rdata_i;
         if (k == m_rsp_at) begin
            if (m_own_d) begin
               e_dv = 1; e_de = m_err;
               e_dd = (m_we || m_err) ? 32'h0 : m_rdata;
            end else begin
               e_iv = 1; e_id = m_rdata;
            end
         end
      end
      check_value("i_ready",   32'(i_req_ready_o), 32'(e_ir));
      check_value("d_ready",   32'(d_req_ready_o), 32'(e_dr));
      check_value("mem_en",    32'(mem_en_o),      32'(e_en));
      check_value("mem_we",    32'(mem_we_o),      32'(e_we));
      check_value("mem_addr",  mem_addr_o,         e_addr);
      check_value("mem_wdata", mem_wdata_o,        e_wdata);
      check_value("mem_be",    32'(mem_be_o),      32'(e_be));
      check_value("i_rsp_v",   32'(i_rsp_valid_o), 32'(e_iv));
      check_value("i_rsp_d",   i_rsp_data_o,       e_id);
      check_value("d_rsp_v",   32'(d_rsp_valid_o), 32'(e_dv));
      check_value("d_rsp_d",   d_rsp_data_o,       e_dd);
      check_value("d_rsp_err", 32'(d_rsp_err_o),   32'(e_de));
      if (busy) begin
         if (k == m_rsp_at) busy = 0;
      end else if (gi) begin
         busy = 1; t_hand = cyc; i_pend = 0; streak = 0;
         m_own_d = 0; m_we = 0; m_err = 0;
         m_addr = i_a - (i_a % 4); m_be = 4'hF; m_wdata = 32'h0;
         m_rsp_at = L + 2;
      end else if (gd) begin
         busy = 1; t_hand = cyc; d_pend = 0;
         if (i_pend && streak < S) streak++;
         w  = (d_w == 2'd3) ? 2 : int'(d_w);
         lo = int'(d_a % 4);
         m_own_d = 1; m_we = d_we;
         m_err   = (w == 1 && lo % 2 == 1) || (w == 2 && lo != 0);
         if (m_err) begin
            m_we = 0; m_addr = 32'h0; m_be = 4'h0; m_wdata = 32'h0;
         end else begin
            m_addr = d_a - 32'(lo);
            m_be   = (w == 0) ? 4'(1 << lo) : (w == 1) ? 4'(3 << lo) : 4'hF;
            if (!d_we)       m_wdata = 32'h0;
            else if (w == 0) m_wdata = d_wd[7:0] * 32'h0101_0101;
            else if (w == 1) m_wdata = d_wd[15:0] * 32'h0001_0001;
            else             m_wdata = d_wd;
         end
         m_rsp_at = (d_we || m_err) ? 2 : L + 2;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      drive_inputs();
      @(negedge clk);
      check_and_advance();
      cyc++;
   endtask

   task automatic drain();
      int n = 0;
      while ((busy || i_pend || d_pend) && n < 100) begin
         step();
         n++;
      end
      if (n >= 100) check_value("drain_timeout", 32'(busy), 32'h0);
   endtask

   task automatic req_d(input logic [31:0] a, input logic [31:0] wd, input bit we, input logic [1:0] w);
      d_pend = 1; d_a = a; d_wd = wd; d_we = we; d_w = w;
      drain();
   endtask

   task automatic req_i(input logic [31:0] a);
      i_pend = 1; i_a = a;
      drain();
   endtask

   task automatic reset_pulse();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      i_pend = 0; d_pend = 0;
      i_req_valid_i = 1'b0; d_req_valid_i = 1'b0;
      busy = 0; streak = 0;
      #1;
      check_and_advance();
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      i_req_valid_i = 1'b0; i_addr_i = 32'h0;
      d_req_valid_i = 1'b0; d_addr_i = 32'h0; d_wdata_i = 32'h0;
      d_write_i = 1'b0; d_width_i = 2'd0; mem_rdata_i = 32'h0;
      i_pend = 0; d_pend = 0; i_a = 32'h0; d_a = 32'h0; d_wd = 32'h0; d_we = 0; d_w = 2'd0;
      gen_pct = 0; cyc = 0; busy = 0; t_hand = 0; streak = 0;
      m_own_d = 0; m_we = 0; m_err = 0; m_addr = 32'h0; m_wdata = 32'h0;
      m_rdata = 32'h0; m_be = 4'h0; m_rsp_at = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_and_advance();
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      req_i(32'h0000_0104);
      req_d(32'h0000_0203, 32'h0000_00AB, 1'b1, 2'd0);
      req_d(32'h0000_0101, 32'h0000_0000, 1'b0, 2'd1);
      req_d(32'h0000_0040, 32'h0000_0000, 1'b0, 2'd2);
      req_d(32'h0000_0046, 32'h0000_BEEF, 1'b1, 2'd1);
      req_d(32'h0000_0082, 32'h1234_5678, 1'b1, 2'd3);

      gen_pct = 100;
      repeat (120) step();
      gen_pct = 0;
      drain();

      gen_pct = 35;
      repeat (1500) step();
      gen_pct = 0;
      drain();

      i_pend = 1; i_a = 32'h0000_0104;
      n = 0;
      while (!(busy && (cyc - t_hand) == 2) && n < 20) begin
         step();
         n++;
      end
      if (n >= 20) check_value("wait_timeout", 32'(busy), 32'h1);
      reset_pulse();
      repeat (6) step();
      req_i(32'h0000_0104);
      repeat (4) step();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
